// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W_DFLT = 5;

   // All-zero word is the canonical NOP of this ISA (sll r0, r0, 0).
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      FLUSH   = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLOCK,
   input  logic         RESET_N,
   input  logic         INC,
   output logic [W-1:0] COUNT
);

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N)
         COUNT <= '0;
      else if (INC && (COUNT != {W{1'b1}}))
         COUNT <= COUNT + 1'b1;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller beside ID: load-use stalls, branch flushes and
// data-memory wait freezes, plus stall/flush statistics.
//
// state   | meaning
// RUN     | normal issue; hazards resolved combinationally each cycle
// MEMWAIT | data memory busy, whole pipeline frozen
// FLUSH   | extra IF/ID flush cycles after a taken branch
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W          = REG_ADDR_W_DFLT,
   parameter int BRANCH_FLUSH_CYCLES = 1,
   parameter int CNT_W               = 16
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic [REG_ADDR_W-1:0] ID_RS,
   input  logic [REG_ADDR_W-1:0] ID_RT,
   input  logic                  ID_USES_RT,
   input  logic                  EX_MEMREAD,
   input  logic [REG_ADDR_W-1:0] EX_RT,
   input  logic                  EX_BRANCH_TAKEN,
   input  logic                  MEM_ACCESS,
   input  logic                  DMEM_READY,
   output logic                  PC_WRITE,
   output logic                  IFID_STALL,
   output logic                  IFID_FLUSH,
   output logic                  IDEX_BUBBLE,
   output logic                  PIPE_FREEZE,
   output logic [1:0]            CTRL_STATE,
   output logic [CNT_W-1:0]      STALL_COUNT,
   output logic [CNT_W-1:0]      FLUSH_COUNT
);

   localparam logic [1:0] ST_RUN     = RUN;
   localparam logic [1:0] ST_MEMWAIT = MEMWAIT;
   localparam logic [1:0] ST_FLUSH   = FLUSH;
   localparam logic [2:0] FLUSH_LOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

   logic [1:0] state, state_nxt;
   logic [2:0] flush_cnt, flush_cnt_nxt;
   logic       memwait, loaduse;

   assign memwait = MEM_ACCESS & ~DMEM_READY;
   assign loaduse = EX_MEMREAD & (EX_RT != '0) &
                    ((EX_RT == ID_RS) | (ID_USES_RT & (EX_RT == ID_RT)));

   always_comb begin
      PC_WRITE      = 1'b0;
      IFID_STALL    = 1'b0;
      IFID_FLUSH    = 1'b0;
      IDEX_BUBBLE   = 1'b0;
      PIPE_FREEZE   = 1'b0;
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      if (!RESET_N) begin
         IFID_FLUSH = 1'b1;
      end else if (state == ST_FLUSH) begin
         // EX holds a bubble here, so a taken-branch indication is ignored.
         if (memwait) begin
            PIPE_FREEZE = 1'b1;
            IFID_STALL  = 1'b1;
         end else begin
            IFID_FLUSH    = 1'b1;
            PC_WRITE      = 1'b1;
            flush_cnt_nxt = flush_cnt - 3'd1;
            if (flush_cnt == 3'd1)
               state_nxt = ST_RUN;
         end
      end else begin
         // RUN, MEMWAIT and the unused encoding share one decision tree.
         state_nxt = ST_RUN;
         if (memwait) begin
            PIPE_FREEZE = 1'b1;
            IFID_STALL  = 1'b1;
            state_nxt   = ST_MEMWAIT;
         end else if (EX_BRANCH_TAKEN) begin
            PC_WRITE    = 1'b1;
            IFID_FLUSH  = 1'b1;
            IDEX_BUBBLE = 1'b1;
            if (BRANCH_FLUSH_CYCLES > 1) begin
               flush_cnt_nxt = FLUSH_LOAD;
               state_nxt     = ST_FLUSH;
            end
         end else if (loaduse) begin
            IFID_STALL  = 1'b1;
            IDEX_BUBBLE = 1'b1;
         end else begin
            PC_WRITE = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= ST_RUN;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   assign CTRL_STATE = state;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .INC     (~PC_WRITE),
      .COUNT   (STALL_COUNT)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .INC     (IFID_FLUSH),
      .COUNT   (FLUSH_COUNT)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random traffic.
module tb_pipeline_hazard_ctrl;

   localparam int BFC   = 3;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rt = 1'b0, ex_memread = 1'b0, ex_br = 1'b0;
   logic       mem_access = 1'b0, dmem_ready = 1'b1;
   logic       pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;
   logic [1:0] ctrl_state;
   logic [CNT_W-1:0] stall_count, flush_count;

   pipeline_hazard_ctrl #(
      .REG_ADDR_W(5), .BRANCH_FLUSH_CYCLES(BFC), .CNT_W(CNT_W)
   ) dut (
      .CLOCK(clk), .RESET_N(rst_n),
      .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RT(id_uses_rt),
      .EX_MEMREAD(ex_memread), .EX_RT(ex_rt), .EX_BRANCH_TAKEN(ex_br),
      .MEM_ACCESS(mem_access), .DMEM_READY(dmem_ready),
      .PC_WRITE(pc_write), .IFID_STALL(ifid_stall), .IFID_FLUSH(ifid_flush),
      .IDEX_BUBBLE(idex_bubble), .PIPE_FREEZE(pipe_freeze),
      .CTRL_STATE(ctrl_state), .STALL_COUNT(stall_count), .FLUSH_COUNT(flush_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst_n;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       memread;
      logic [4:0] ex_rt;
      logic       br;
      logic       macc;
      logic       rdy;
   } stim_t;

   typedef struct packed {
      logic             pcw;
      logic             stall;
      logic             flush;
      logic             bubble;
      logic             freeze;
      logic [1:0]       st;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } resp_t;

   resp_t q_exp[$];
   int    n_cmp = 0;
   int    n_mis = 0;
   string q_tag[$];

   // Reference model: remaining flush cycles, whether we are waiting on memory, and totals.
   int  m_flush_left = 0;
   bit  m_wait       = 0;
   int  m_sc         = 0;
   int  m_fc         = 0;

   function automatic stim_t idle();
      stim_t s = '0;
      s.rst_n = 1'b1;
      s.rdy   = 1'b1;
      return s;
   endfunction

   task automatic model_step(input stim_t s, input string tag);
      resp_t e = '0;
      bit mw, lu;
      mw = s.macc && !s.rdy;
      lu = s.memread && (s.ex_rt != 0) &&
           ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
      if (!s.rst_n) begin
         m_flush_left = 0; m_wait = 0; m_sc = 0; m_fc = 0;
         e.flush = 1'b1;
      end else begin
         e.st = (m_flush_left > 0) ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
         e.sc = CNT_W'(m_sc);
         e.fc = CNT_W'(m_fc);
         if (m_flush_left > 0) begin
            m_wait = 0;
            if (mw) begin
               e.freeze = 1; e.stall = 1;
            end else begin
               e.flush = 1; e.pcw = 1;
               m_flush_left--;
            end
         end else if (mw) begin
            e.freeze = 1; e.stall = 1; m_wait = 1;
         end else begin
            m_wait = 0;
            if (s.br) begin
               e.pcw = 1; e.flush = 1; e.bubble = 1;
               m_flush_left = BFC - 1;
            end else if (lu) begin
               e.stall = 1; e.bubble = 1;
            end else begin
               e.pcw = 1;
            end
         end
         if (!e.pcw) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
         if (e.flush) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      end
      q_exp.push_back(e);
      q_tag.push_back(tag);
   endtask

   task automatic drive(input stim_t s, input string tag);
      @(posedge clk);
      #1;
      rst_n      = s.rst_n;
      id_rs      = s.rs;
      id_rt      = s.rt;
      id_uses_rt = s.uses_rt;
      ex_memread = s.memread;
      ex_rt      = s.ex_rt;
      ex_br      = s.br;
      mem_access = s.macc;
      dmem_ready = s.rdy;
      model_step(s, tag);
   endtask

   // Monitor: outputs are valid every cycle, sampled mid-cycle on the falling edge.
   initial begin
      resp_t e, a;
      string t;
      forever begin
         @(negedge clk);
         if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            a = {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
                 ctrl_state, stall_count, flush_count};
            n_cmp++;
            if (a !== e) begin
               n_mis++;
               $display("FAIL %s @%0t: got pcw/stall/flush/bub/frz=%b%b%b%b%b st=%0d sc=%0d fc=%0d, want %b%b%b%b%b st=%0d sc=%0d fc=%0d",
                        t, $time, a.pcw, a.stall, a.flush, a.bubble, a.freeze, a.st, a.sc, a.fc,
                        e.pcw, e.stall, e.flush, e.bubble, e.freeze, e.st, e.sc, e.fc);
            end
            n_cmp++;
            if (ifid_stall && ifid_flush) begin
               n_mis++;
               $display("FAIL stall_flush_exclusive %s @%0t: both asserted, want not both", t, $time);
            end
         end
      end
   end

   initial begin
      stim_t s;
      // Reset held for three cycles
      s = idle(); s.rst_n = 0;
      for (int i = 0; i < 3; i++) drive(s, "reset");
      drive(idle(), "post_reset");
      // Load-use on rs, then the same with r0 as destination
      s = idle(); s.memread = 1; s.ex_rt = 5; s.rs = 5;
      drive(s, "loaduse");
      drive(idle(), "loaduse_after");
      s.ex_rt = 0; s.rs = 0;
      drive(s, "loaduse_r0");
      s = idle(); s.memread = 1; s.ex_rt = 7; s.rt = 7; s.uses_rt = 1;
      drive(s, "loaduse_rt");
      s.uses_rt = 0;
      drive(s, "rt_unused");
      // Taken branch: three flush cycles
      s = idle(); s.br = 1;
      drive(s, "branch");
      for (int i = 0; i < 4; i++) drive(idle(), "branch_tail");
      // Memory wait for four cycles then ready
      s = idle(); s.macc = 1; s.rdy = 0;
      for (int i = 0; i < 4; i++) drive(s, "memwait");
      s.rdy = 1;
      drive(s, "mem_ready");
      // Simultaneous memwait + branch + load-use, then memwait inside the flush
      s = idle(); s.macc = 1; s.rdy = 0; s.br = 1; s.memread = 1; s.ex_rt = 3; s.rs = 3;
      drive(s, "simul_freeze");
      drive(s, "simul_freeze");
      s.rdy = 1;
      drive(s, "simul_ready");
      s.br = 0; s.rdy = 0;
      drive(s, "flush_memwait");
      drive(s, "flush_memwait");
      s.rdy = 1;
      for (int i = 0; i < 4; i++) drive(s, "flush_resume");
      // Saturation of the stall counter
      s = idle(); s.rst_n = 0;
      drive(s, "reset2");
      s = idle(); s.memread = 1; s.ex_rt = 9; s.rs = 9;
      for (int i = 0; i < 20; i++) drive(s, "saturate");
      // Reset mid-flush
      s = idle(); s.br = 1;
      drive(s, "branch2");
      drive(idle(), "mid_flush");
      s = idle(); s.rst_n = 0;
      drive(s, "reset_mid_flush");
      drive(idle(), "after_abort");
      // Random traffic with a small register pool so hazards collide often
      for (int i = 0; i < 600; i++) begin
         s = idle();
         s.rst_n   = ($urandom_range(0, 59) != 0);
         s.rs      = 5'($urandom_range(0, 3));
         s.rt      = 5'($urandom_range(0, 3));
         s.ex_rt   = 5'($urandom_range(0, 3));
         s.uses_rt = 1'($urandom_range(0, 1));
         s.memread = ($urandom_range(0, 2) == 0);
         s.br      = ($urandom_range(0, 5) == 0);
         s.macc    = ($urandom_range(0, 2) == 0);
         s.rdy     = ($urandom_range(0, 2) != 0);
         drive(s, "random");
      end
      @(negedge clk);
      @(negedge clk);
      if (q_exp.size() != 0) begin
         n_mis++;
         $display("FAIL drain: %0d expected responses left, want 0", q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
